// File: rtl/fp_pkg.sv
// Shared definitions for the fingerprint-sensor packet receiver: parser states,
// framing constants, default device address and packet identifiers.
package fp_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR1,
    ST_ADDR,
    ST_PID,
    ST_LEN_H,
    ST_LEN_L,
    ST_DATA,
    ST_CHK_H,
    ST_CHK_L
  } fp_state_t;

  localparam logic [7:0]  FP_HDR0         = 8'hEF;
  localparam logic [7:0]  FP_HDR1         = 8'h01;
  localparam logic [31:0] FP_DEFAULT_ADDR = 32'hFFFFFFFF;

  localparam logic [7:0]  FP_PID_CMD      = 8'h01;
  localparam logic [7:0]  FP_PID_DATA     = 8'h02;
  localparam logic [7:0]  FP_PID_ACK      = 8'h07;
  localparam logic [7:0]  FP_PID_END_DATA = 8'h08;

  // Address bytes arrive most-significant first; idx 0 selects ADDR[31:24].
  function automatic logic [7:0] fp_addr_byte(input logic [31:0] addr, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = addr[31:24];
      2'd1:    b = addr[23:16];
      2'd2:    b = addr[15:8];
      default: b = addr[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/fp_payload_ram.sv
// Payload byte buffer: one synchronous write port, asynchronous read port.
// Latency: write visible one clock after wr_en; read is combinational.
// Backpressure: none, writes are accepted every cycle.
module fp_payload_ram #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_Clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_dat,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_dat
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge i_Clock) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/fp_packet_rx.sv
// Byte-stream parser for sensor packets (EF 01 | ADDR | PID | LEN | payload | CHK) into a payload buffer.
// Latency: verdict pulses/valid one clock after the CHK_L strobe; optional inter-byte timeout via FP_RX_TIMEOUT_EN.
// Backpressure: none on input; a good packet arriving while one is still held is dropped with o_Overrun.
module fp_packet_rx
  import fp_pkg::*;
#(
  parameter int          MAX_PAYLOAD  = 32,
  parameter logic [31:0] DEV_ADDR     = FP_DEFAULT_ADDR,
  parameter int          TIMEOUT_CLKS = 100000
) (
  input  logic                           i_Clock,
  input  logic                           i_Rst_n,
  input  logic                           i_Rx_DV,
  input  logic [7:0]                     i_Rx_Byte,
  input  logic                           i_Pkt_Ack,
  input  logic [$clog2(MAX_PAYLOAD)-1:0] i_Rd_Addr,
  output logic [7:0]                     o_Rd_Data,
  output logic                           o_Pkt_Valid,
  output logic [7:0]                     o_Pid,
  output logic [15:0]                    o_Len,
  output logic                           o_Pkt_Err,
  output logic                           o_Overrun
);

  localparam int          AW     = $clog2(MAX_PAYLOAD);
  localparam logic [15:0] MaxLen = 16'(MAX_PAYLOAD + 2);

  fp_state_t   state;
  logic [1:0]  addr_cnt;
  logic [15:0] data_cnt;
  logic [15:0] payload_len;
  logic [15:0] chk_sum;
  logic [7:0]  pid_q;
  logic [7:0]  len_h;
  logic [7:0]  chk_h;
  logic        accept;

  logic [15:0] len_rx;
  logic [15:0] chk_nxt;
  logic        len_bad;
  logic        wr_en;

  always_comb begin
    len_rx  = {len_h, i_Rx_Byte};
    chk_nxt = chk_sum + {8'h00, i_Rx_Byte};
    len_bad = (len_rx < 16'd2) || (len_rx > MaxLen);
    wr_en   = i_Rx_DV && (state == ST_DATA) && accept;
  end

`ifdef FP_RX_TIMEOUT_EN
  localparam logic [31:0] TmoLast = 32'(TIMEOUT_CLKS - 1);
  logic [31:0] tmo_cnt;
`else
  // The timeout length only matters when the timeout counter is built in.
  if (TIMEOUT_CLKS < 1) begin : g_tmo_cfg_unused
  end
`endif

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state       <= ST_IDLE;
      addr_cnt    <= '0;
      data_cnt    <= '0;
      payload_len <= '0;
      chk_sum     <= '0;
      pid_q       <= '0;
      len_h       <= '0;
      chk_h       <= '0;
      accept      <= 1'b0;
      o_Pkt_Valid <= 1'b0;
      o_Pid       <= '0;
      o_Len       <= '0;
      o_Pkt_Err   <= 1'b0;
      o_Overrun   <= 1'b0;
`ifdef FP_RX_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      o_Pkt_Err <= 1'b0;
      o_Overrun <= 1'b0;
      if (i_Pkt_Ack && o_Pkt_Valid) o_Pkt_Valid <= 1'b0;

      if (i_Rx_DV) begin
        case (state)
          ST_IDLE: if (i_Rx_Byte == FP_HDR0) state <= ST_HDR1;
          ST_HDR1: begin
            if (i_Rx_Byte == FP_HDR1) begin
              state    <= ST_ADDR;
              addr_cnt <= '0;
            end else if (i_Rx_Byte != FP_HDR0) begin
              state <= ST_IDLE;
            end
          end
          ST_ADDR: begin
            if (i_Rx_Byte != fp_addr_byte(DEV_ADDR, addr_cnt)) begin
              o_Pkt_Err <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              addr_cnt <= addr_cnt + 2'd1;
              if (addr_cnt == 2'd3) state <= ST_PID;
            end
          end
          ST_PID: begin
            pid_q   <= i_Rx_Byte;
            chk_sum <= {8'h00, i_Rx_Byte};
            state   <= ST_LEN_H;
          end
          ST_LEN_H: begin
            len_h   <= i_Rx_Byte;
            chk_sum <= chk_nxt;
            state   <= ST_LEN_L;
          end
          ST_LEN_L: begin
            chk_sum <= chk_nxt;
            if (len_bad) begin
              o_Pkt_Err <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              payload_len <= len_rx - 16'd2;
              data_cnt    <= '0;
              // Sampled before any same-cycle ack takes effect, so that ack cannot grant acceptance.
              accept      <= !o_Pkt_Valid;
              state       <= (len_rx == 16'd2) ? ST_CHK_H : ST_DATA;
            end
          end
          ST_DATA: begin
            chk_sum  <= chk_nxt;
            data_cnt <= data_cnt + 16'd1;
            if (data_cnt + 16'd1 == payload_len) state <= ST_CHK_H;
          end
          ST_CHK_H: begin
            chk_h <= i_Rx_Byte;
            state <= ST_CHK_L;
          end
          ST_CHK_L: begin
            if ({chk_h, i_Rx_Byte} != chk_sum) begin
              o_Pkt_Err <= 1'b1;
            end else if (accept) begin
              o_Pkt_Valid <= 1'b1;
              o_Pid       <= pid_q;
              o_Len       <= payload_len;
            end else begin
              o_Overrun <= 1'b1;
            end
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end

`ifdef FP_RX_TIMEOUT_EN
      if (i_Rx_DV || state == ST_IDLE) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt == TmoLast) begin
        tmo_cnt   <= '0;
        o_Pkt_Err <= 1'b1;
        state     <= ST_IDLE;
      end else begin
        tmo_cnt <= tmo_cnt + 32'd1;
      end
`endif
    end
  end

  fp_payload_ram #(
    .DEPTH (MAX_PAYLOAD),
    .AW    (AW)
  ) u_payload_ram (
    .i_Clock (i_Clock),
    .wr_en   (wr_en),
    .wr_addr (data_cnt[AW-1:0]),
    .wr_dat  (i_Rx_Byte),
    .rd_addr (i_Rd_Addr),
    .rd_dat  (o_Rd_Data)
  );

endmodule
